// File: rtl/link_monitor.sv
// Link-up monitor: signal-detect hysteresis, descrambler lock wait and a
// saturating counter of link drops, all driven by a single Moore FSM.
module link_monitor #(
  parameter logic [15:0] STABILIZE_TIME      = 16'd50000,
  parameter logic [15:0] TEST_STABILIZE_TIME = 16'd125,
  parameter logic [15:0] LOCK_TIMEOUT        = 16'hffff
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_status,
  input  logic       locked,
  input  logic       test_mode,
  input  logic       clear_drops,
  output logic       desc_enable,
  output logic       link_status,
  output logic [7:0] link_drops,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    DOWN       = 2'b00,
    HYSTERESIS = 2'b01,
    WAIT_LOCK  = 2'b10,
    UP         = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  link_drops_q, link_drops_d;
  logic        desc_enable_q, desc_enable_d;
  logic        link_status_q, link_status_d;

  // One timer serves both timed states; it is loaded on entry and only
  // decremented while nonzero, so reaching zero is the exit condition.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    link_drops_d = link_drops_q;

    case (state_q)
      DOWN: begin
        if (signal_status) begin
          state_d = HYSTERESIS;
          timer_d = test_mode ? TEST_STABILIZE_TIME : STABILIZE_TIME;
        end
      end
      HYSTERESIS: begin
        if (!signal_status) begin
          state_d = DOWN;
        end else if (timer_q == 16'd0) begin
          state_d = WAIT_LOCK;
          timer_d = LOCK_TIMEOUT;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      WAIT_LOCK: begin
        if (!signal_status) begin
          state_d = DOWN;
        end else if (locked) begin
          state_d = UP;
        end else if (timer_q == 16'd0) begin
          state_d = DOWN;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      UP: begin
        if (!signal_status || !locked) begin
          state_d = DOWN;
          if (link_drops_q != 8'hff) begin
            link_drops_d = link_drops_q + 8'd1;
          end
        end
      end
      default: state_d = DOWN;
    endcase

    if (clear_drops) begin
      link_drops_d = 8'd0;
    end

    // Outputs decode the next state so the registered copies line up with state_q.
    desc_enable_d = (state_d == WAIT_LOCK) || (state_d == UP);
    link_status_d = (state_d == UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= DOWN;
      timer_q       <= 16'd0;
      link_drops_q  <= 8'd0;
      desc_enable_q <= 1'b0;
      link_status_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      link_drops_q  <= link_drops_d;
      desc_enable_q <= desc_enable_d;
      link_status_q <= link_status_d;
    end
  end

  assign desc_enable = desc_enable_q;
  assign link_status = link_status_q;
  assign link_drops  = link_drops_q;
  assign state       = state_q;

endmodule
